led_pulse_tx: RTL

LED_PULSE_TX -- requirements
Module: led_pulse_tx

---
 rtl/led_tx_pkg.sv | 19 +
 rtl/led_pulse_tx_tick_gen.sv | 26 ++
 rtl/led_pulse_tx.sv | 109 ++++++++++
 3 files changed

// File: rtl/led_tx_pkg.sv
// Shared types and defaults for the LED blink transmitter and its scan-tick helpers.
package led_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } led_state_e;

  localparam int DEF_DIV_RATIO = 10;
  localparam int DEF_ON_TICKS  = 4;
  localparam int DEF_OFF_TICKS = 4;
  localparam int DEF_CNT_W     = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_pulse_tx_tick_gen.sv
// Free-running scan-tick divider; holds at zero while disabled or cleared.
module tick_gen #(
  parameter int DIV_RATIO = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DW = $clog2(DIV_RATIO);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_RATIO - 1);

  logic [DW-1:0] r_div;

  always_ff @(posedge clk) begin
    if (rst || clr)
      r_div <= '0;
    else if (en)
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
  end

  assign tick = en && (r_div == DIV_LAST);

endmodule

// File: rtl/led_pulse_tx.sv
// Blinks the LED req_count times: ON_TICKS scan ticks lit, OFF_TICKS dark, then pulses done.
module led_pulse_tx
  import led_tx_pkg::*;
#(
  parameter int DIV_RATIO = DEF_DIV_RATIO,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_count,
  output logic             req_ready,
  input  logic             abort,
  output logic             led,
  output logic             busy,
  output logic             done
);

  localparam int PH_W = $clog2(max2(ON_TICKS, OFF_TICKS) + 1);
  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);

  led_state_e       r_state, w_state_nxt;
  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_remaining;
  logic             r_led, r_busy, r_done;
  logic             w_led_nxt, w_busy_nxt, w_done_nxt;
  logic             w_accept, w_in_seq, w_kill, w_tick;
  logic             w_on_end, w_off_end, w_last_blink;

  assign req_ready    = (r_state == ST_IDLE) && !abort;
  assign w_accept     = req_valid && req_ready;
  assign w_in_seq     = (r_state != ST_IDLE);
  assign w_kill       = abort && w_in_seq;
  assign w_on_end     = (r_state == ST_ON)  && w_tick && (r_phase == ON_LAST);
  assign w_off_end    = (r_state == ST_OFF) && w_tick && (r_phase == OFF_LAST);
  assign w_last_blink = (r_remaining == CNT_W'(1));

  tick_gen #(.DIV_RATIO(DIV_RATIO)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_kill || w_accept),
    .en   (w_in_seq),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Abort outranks a coincident phase-ending tick.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && (req_count != '0)) w_state_nxt = ST_ON;
      ST_ON: begin
        if (w_kill)        w_state_nxt = ST_IDLE;
        else if (w_on_end) w_state_nxt = ST_OFF;
      end
      ST_OFF: begin
        if (w_kill)         w_state_nxt = ST_IDLE;
        else if (w_off_end) w_state_nxt = w_last_blink ? ST_IDLE : ST_ON;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Zero-count requests complete immediately without lighting the LED.
  always_comb begin
    w_led_nxt  = (w_state_nxt == ST_ON);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (w_accept && (req_count == '0)) ||
                 (w_off_end && !abort && w_last_blink);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase     <= '0;
      r_remaining <= '0;
    end else begin
      if (w_accept)
        r_remaining <= req_count;
      else if (!w_kill && w_off_end && !w_last_blink)
        r_remaining <= r_remaining - CNT_W'(1);

      if (w_state_nxt != r_state || w_kill)
        r_phase <= '0;
      else if (w_tick)
        r_phase <= r_phase + PH_W'(1);
    end
  end

  assign led  = r_led;
  assign busy = r_busy;
  assign done = r_done;

endmodule
